// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : rsa_exp_ctrl                                                     |
// | Purpose  : Left-to-right square-and-multiply sequencer for Montgomery       |
// |            modular exponentiation over a shared start/done multiplier.      |
// | Option   : RSA_CTRL_CONST_TIME_EN - run MULT for every exponent bit.        |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module rsa_exp_ctrl #(
   parameter int WIDTH = 1024,
   parameter int EXP_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] r_n,
   input  logic [WIDTH-1:0] r2_n,
   input  logic [EXP_W-1:0] exp,
   input  logic [31:0]      exp_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   input  logic             mm_done,
   input  logic [WIDTH-1:0] mm_result
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TO_MONT   = 3'd1,
      S_SQUARE    = 3'd2,
      S_MULT      = 3'd3,
      S_FROM_MONT = 3'd4,
      S_FIN       = 3'd5
   } state_t;

   localparam logic [EXP_W-1:0] c_exp_one  = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_mont_one = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   m_q,        m_d;
   logic [WIDTH-1:0]   r2_q,       r2_d;
   logic [EXP_W-1:0]   exp_q,      exp_d;
   logic               len_zero_q, len_zero_d;
   logic [31:0]        i_q,        i_d;
   logic [WIDTH-1:0]   a_q,        a_d;
   logic [WIDTH-1:0]   xt_q,       xt_d;
   logic [WIDTH-1:0]   result_q,   result_d;
   logic               err_q,      err_d;
   logic               issued_q,   issued_d;

   logic               w_bit;
   logic               w_last_bit;
   logic               w_mult_state;
   state_t             w_adv_state;
   logic [31:0]        w_adv_i;

   assign w_bit        = |(exp_q & (c_exp_one << i_q));
   assign w_last_bit   = (i_q == 32'd0);
   assign w_adv_state  = w_last_bit ? S_FROM_MONT : S_SQUARE;
   assign w_adv_i      = w_last_bit ? i_q : (i_q - 32'd1);
   assign w_mult_state = (state_q == S_TO_MONT) || (state_q == S_SQUARE) ||
                         (state_q == S_MULT)    || (state_q == S_FROM_MONT);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         m_q        <= '0;
         r2_q       <= '0;
         exp_q      <= '0;
         len_zero_q <= 1'b0;
         i_q        <= '0;
         a_q        <= '0;
         xt_q       <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         issued_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         r2_q       <= r2_d;
         exp_q      <= exp_d;
         len_zero_q <= len_zero_d;
         i_q        <= i_d;
         a_q        <= a_d;
         xt_q       <= xt_d;
         result_q   <= result_d;
         err_q      <= err_d;
         issued_q   <= issued_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      r2_d       = r2_q;
      exp_d      = exp_q;
      len_zero_d = len_zero_q;
      i_d        = i_q;
      a_d        = a_q;
      xt_d       = xt_q;
      result_d   = result_q;
      err_d      = err_q;
      issued_d   = issued_q;

      // issued_q marks that this state's single mm_start has gone out
      if (w_mult_state) begin
         issued_d = mm_done ? 1'b0 : 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d = (exp_len > 32'(EXP_W));
               if (exp_len > 32'(EXP_W)) begin
                  state_d = S_FIN;
               end else begin
                  m_d        = m;
                  r2_d       = r2_n;
                  exp_d      = exp;
                  len_zero_d = (exp_len == 32'd0);
                  i_d        = exp_len - 32'd1;
                  a_d        = r_n;
                  xt_d       = '0;
                  issued_d   = 1'b0;
                  state_d    = S_TO_MONT;
               end
            end
         end
         S_TO_MONT: begin
            if (mm_done) begin
               xt_d    = mm_result;
               state_d = len_zero_q ? S_FROM_MONT : S_SQUARE;
            end
         end
         S_SQUARE: begin
            if (mm_done) begin
               a_d = mm_result;
`ifdef RSA_CTRL_CONST_TIME_EN
               state_d = S_MULT;
`else
               if (w_bit) begin
                  state_d = S_MULT;
               end else begin
                  state_d = w_adv_state;
                  i_d     = w_adv_i;
               end
`endif
            end
         end
         S_MULT: begin
            if (mm_done) begin
`ifdef RSA_CTRL_CONST_TIME_EN
               // dummy multiply for zero bits keeps the op count data-independent
               if (w_bit) begin
                  a_d = mm_result;
               end
`else
               a_d = mm_result;
`endif
               state_d = w_adv_state;
               i_d     = w_adv_i;
            end
         end
         S_FROM_MONT: begin
            if (mm_done) begin
               result_d = mm_result;
               state_d  = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy     = w_mult_state;
      done     = (state_q == S_FIN);
      err      = err_q;
      result   = result_q;
      mm_start = w_mult_state && !issued_q;
      mm_a     = '0;
      mm_b     = '0;
      case (state_q)
         S_TO_MONT: begin
            mm_a = m_q;
            mm_b = r2_q;
         end
         S_SQUARE: begin
            mm_a = a_q;
            mm_b = a_q;
         end
         S_MULT: begin
            mm_a = a_q;
            mm_b = xt_q;
         end
         S_FROM_MONT: begin
            mm_a = a_q;
            mm_b = c_mont_one;
         end
         default: begin
            mm_a = '0;
            mm_b = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rsa_exp_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_rsa_exp_ctrl                                                  |
// | Purpose  : Directed self-checking bench for rsa_exp_ctrl with a k=3         |
// |            Montgomery multiplier model and a plain modexp golden reference. |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_rsa_exp_ctrl;

   localparam int W  = 1024;
   localparam int EW = 32;
   localparam int K  = 3;

`ifdef RSA_CTRL_CONST_TIME_EN
   localparam int OPS_A = 34;
   localparam int LAT_A = 137;
   localparam int OPS_F = 66;
   localparam int LAT_F = 265;
`else
   localparam int OPS_A = 25;
   localparam int LAT_A = 101;
   localparam int OPS_F = 36;
   localparam int LAT_F = 145;
`endif

   localparam logic [W-1:0] N_MOD = {32{32'hccd6249d}};
   localparam logic [W-1:0] M_MSG = {32{32'h8eb62afe}};

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [W-1:0]  m, r_n, r2_n;
   logic [EW-1:0] exp;
   logic [31:0]   exp_len;
   logic          busy, done, err;
   logic [W-1:0]  result;
   logic          mm_start;
   logic [W-1:0]  mm_a, mm_b;
   logic          mm_done;
   logic [W-1:0]  mm_result;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   rsa_exp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .m         (m),
      .r_n       (r_n),
      .r2_n      (r2_n),
      .exp       (exp),
      .exp_len   (exp_len),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .result    (result),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_done   (mm_done),
      .mm_result (mm_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (low 128 bits)", tag, obs[127:0], expv[127:0]);
      end
   endtask

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      r = '0;
      for (int i = W - 1; i >= 0; i--) begin
         r = r << 1;
         if (r >= {1'b0, N_MOD}) r = r - {1'b0, N_MOD};
         if (b[i]) r = r + {1'b0, a};
         if (r >= {1'b0, N_MOD}) r = r - {1'b0, N_MOD};
      end
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [EW-1:0] e, input int len);
      logic [W-1:0] x;
      x = {{(W-1){1'b0}}, 1'b1};
      for (int i = len - 1; i >= 0; i--) begin
         x = mulmod(x, x);
         if (e[i]) x = mulmod(x, b);
      end
      return x;
   endfunction

   function automatic logic [W-1:0] pow2mod(input int k);
      logic [W:0] x;
      x = {{W{1'b0}}, 1'b1};
      for (int i = 0; i < k; i++) begin
         x = x << 1;
         if (x >= {1'b0, N_MOD}) x = x - {1'b0, N_MOD};
      end
      return x[W-1:0];
   endfunction

   function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W+1:0] s;
      s = '0;
      for (int i = 0; i < W; i++) begin
         if (a[i]) s = s + {2'b00, b};
         if (s[0]) s = s + {2'b00, N_MOD};
         s = s >> 1;
      end
      if (s >= {2'b00, N_MOD}) s = s - {2'b00, N_MOD};
      return s[W-1:0];
   endfunction

   // Multiplier model: mm_done exactly K cycles after mm_start.
   logic         pend;
   int           cnt;
   int           ops = 0;
   logic [W-1:0] lat_a, lat_b;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend    <= 1'b0;
         cnt     <= 0;
         mm_done <= 1'b0;
      end else begin
         mm_done <= 1'b0;
         if (mm_start) begin
            pend      <= 1'b1;
            cnt       <= 1;
            lat_a     <= mm_a;
            lat_b     <= mm_b;
            mm_result <= montmul(mm_a, mm_b);
            ops       <= ops + 1;
         end else if (pend) begin
            if (cnt == K - 1) begin
               mm_done <= 1'b1;
               pend    <= 1'b0;
            end else begin
               cnt <= cnt + 1;
            end
         end
      end
   end

   int proto_bad = 0;
   int busy_cyc  = 0;
   always @(negedge clk) begin
      if (resetn) begin
         if ((pend || mm_done) && (mm_a !== lat_a || mm_b !== lat_b)) proto_bad++;
         if (pend && mm_start) proto_bad++;
         if (busy) busy_cyc++;
      end
   end

   logic [W-1:0] rn_v, r2_v;

   task automatic run(input logic [EW-1:0] e, input logic [31:0] len, input int repulse_at,
                      input int abort_at, output int lat, output int nops, output int nbusy);
      int c0, o0, b0;
      @(negedge clk);
      m = M_MSG; r_n = rn_v; r2_n = r2_v; exp = e; exp_len = len; start = 1'b1;
      c0 = cyc; o0 = ops; b0 = busy_cyc;
      lat = -1;
      @(negedge clk);
      start = 1'b0;
      m = ~M_MSG; r_n = '0; r2_n = '0; exp = ~e; exp_len = 32'd7;
      for (int t = 1; t < 2000; t++) begin
         if (done) begin
            lat = cyc - c0;
            break;
         end
         if (t == abort_at) begin
            resetn = 1'b0;
            lat = -2;
            break;
         end
         if (t == repulse_at) begin
            exp = e ^ 32'h0000_00ff;
            exp_len = len;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      nops  = ops - o0;
      nbusy = busy_cyc - b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin : main
      logic [W-1:0] gold_a, gold_f;
      int lat, nops, nbusy;

      resetn = 1'b0; start = 1'b0;
      m = '0; r_n = '0; r2_n = '0; exp = '0; exp_len = '0;
      rn_v   = pow2mod(W);
      r2_v   = pow2mod(2 * W);
      gold_a = modexp(M_MSG, 32'h0000_9985, 16);
      gold_f = modexp(M_MSG, 32'h8000_0001, 32);

      repeat (3) @(negedge clk);
      chk("rst_busy",     W'(busy),     '0);
      chk("rst_done",     W'(done),     '0);
      chk("rst_err",      W'(err),      '0);
      chk("rst_result",   result,       '0);
      chk("rst_mm_start", W'(mm_start), '0);
      chk("rst_mm_ab",    mm_a | mm_b,  '0);
      resetn = 1'b1;

      // main exponent 0x9985 over 16 bits
      run(32'h0000_9985, 32'd16, 0, 0, lat, nops, nbusy);
      chk("a_lat",    W'(lat),   W'(LAT_A));
      chk("a_ops",    W'(nops),  W'(OPS_A));
      chk("a_result", result,    gold_a);
      chk("a_busy",   W'(nbusy), W'(LAT_A - 1));
      chk("a_err",    W'(err),   '0);
      @(negedge clk);
      chk("a_done_pulse", W'(done), '0);

      // zero-length exponent
      run(32'h0000_ffff, 32'd0, 0, 0, lat, nops, nbusy);
      chk("z_lat",    W'(lat),  W'(9));
      chk("z_ops",    W'(nops), W'(2));
      chk("z_result", result,   {{(W-1){1'b0}}, 1'b1});

      // exponent 1 returns M
      run(32'h0000_0001, 32'd1, 0, 0, lat, nops, nbusy);
      chk("one_lat",    W'(lat),  W'(17));
      chk("one_ops",    W'(nops), W'(4));
      chk("one_result", result,   M_MSG);

      // exp_len beyond EXP_W is rejected without touching the multiplier
      run(32'h0000_9985, 32'd33, 0, 0, lat, nops, nbusy);
      chk("err_lat",    W'(lat),   W'(1));
      chk("err_flag",   W'(err),   W'(1));
      chk("err_ops",    W'(nops),  '0);
      chk("err_busy",   W'(nbusy), '0);
      chk("err_result", result,    M_MSG);

      // start re-pulsed while busy is ignored
      run(32'h0000_9985, 32'd16, 20, 0, lat, nops, nbusy);
      chk("rep_lat",    W'(lat),  W'(LAT_A));
      chk("rep_ops",    W'(nops), W'(OPS_A));
      chk("rep_result", result,   gold_a);
      chk("rep_err",    W'(err),  '0);

      // exp_len equal to EXP_W is accepted
      run(32'h8000_0001, 32'd32, 0, 0, lat, nops, nbusy);
      chk("full_lat",    W'(lat),  W'(LAT_F));
      chk("full_ops",    W'(nops), W'(OPS_F));
      chk("full_result", result,   gold_f);
      chk("full_err",    W'(err),  '0);

      // reset mid-operation
      run(32'h0000_9985, 32'd16, 0, 50, lat, nops, nbusy);
      #1;
      chk("abort_busy",   W'(busy),     '0);
      chk("abort_done",   W'(done),     '0);
      chk("abort_err",    W'(err),      '0);
      chk("abort_result", result,       '0);
      chk("abort_mm",     W'(mm_start) | mm_a | mm_b, '0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      run(32'h0000_9985, 32'd16, 0, 0, lat, nops, nbusy);
      chk("post_lat",    W'(lat),  W'(LAT_A));
      chk("post_ops",    W'(nops), W'(OPS_A));
      chk("post_result", result,   gold_a);

      chk("mm_protocol", W'(proto_bad), '0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Sequencer for Montgomery modular exponentiation (left-to-right square-and-multiply) in the RSA datapath. It takes the operands that `rsa_hw` receives from software: message, R mod N, R² mod N, exponent and exponent length. It drives a shared Montgomery multiplier through a start/done handshake, holds the accumulator and Montgomery-domain message, and returns M^t mod N with a done pulse. It sits between the command/register layer and the multiplier core.

## Interface
- `WIDTH`, 1024: operand/modulus width in bits.
- `EXP_W`, 32: exponent register width.
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: asynchronous active-low reset.
- `start`  in  1: begin exponentiation; sampled only in IDLE.
- `m`  in  WIDTH: message M (< N).
- `r_n`  in  WIDTH: R mod N.
- `r2_n`  in  WIDTH: R² mod N.
- `exp`  in  EXP_W: exponent t.
- `exp_len`  in  32: number of significant exponent bits processed, MSB = bit exp_len-1.
- `busy`  out  1: high from the cycle after start is accepted until done.
- `done`  out  1: one-cycle pulse, result valid.
- `err`  out  1: exp_len > EXP_W on the last accepted start; held until next start.
- `result`  out  WIDTH: M^t mod N; held until next accepted start.
- `mm_start`  out  1: one-cycle pulse to multiplier.
- `mm_a`, `mm_b`  out  WIDTH: multiplier operands.
- `mm_done`  in  1: one-cycle pulse, `mm_result` valid.
- `mm_result`  in  WIDTH: MontMul(a,b) = a·b·R⁻¹ mod N.

## Operation
- Inputs `m`, `r_n`, `r2_n`, `exp`, `exp_len` latched on the accepting edge; later changes ignored.
- States: IDLE, TO_MONT, SQUARE, MULT, FROM_MONT, FIN.
- IDLE + start: if exp_len > EXP_W → FIN with err=1, no multiplier op. Otherwise X~ register cleared, A ← r_n, bit index i ← exp_len-1 → TO_MONT.
- TO_MONT: mm_a=M, mm_b=R² mod N; result → X~. Next: SQUARE if exp_len>0, else FROM_MONT.
- SQUARE: mm_a=mm_b=A; result → A. Next: MULT if exp[i]=1, else bit-advance.
- MULT: mm_a=A, mm_b=X~; result → A; then bit-advance.
- Bit-advance: if i=0 → FROM_MONT, else i ← i-1 → SQUARE.
- FROM_MONT: mm_a=A, mm_b=1 (zero-extended); result → `result` register → FIN.
- FIN: done=1 for one cycle → IDLE.
- `start` while busy: ignored, no queuing.
- Operation count n = 2 + exp_len + popcount(exp[exp_len-1:0]).
- Reset values: busy=0, done=0, err=0, result=0, mm_start=0, mm_a=0, mm_b=0, state IDLE.
- Reset mid-operation: immediate abort to IDLE. The multiplier shares `resetn`. A `mm_done` arriving in IDLE/FIN is ignored.

## Timing
- Start accepted at edge of cycle 0. First `mm_start` in cycle 1.
- Each multiply state asserts `mm_start` in its first cycle only. `mm_a`/`mm_b` stay stable until `mm_done` is sampled.
- `mm_done` sampled high: result captured at that edge. The next state's `mm_start` is in the following cycle, with no bubble.
- Multiplier with done k cycles after start: each op = k+1 cycles. `done` is in cycle 1 + n·(k+1).
- err path: `done` in cycle 1, `busy` never asserted, `result` unchanged.
- `busy` falls in the same cycle `done` rises.

## Configuration
- `RSA_CTRL_CONST_TIME_EN` defined:
  - MULT is executed for every bit.
  - When exp[i]=0, the MULT result is discarded and A is unchanged.
  - n = 2 + 2·exp_len, independent of exponent value (timing side-channel hardening).
- Undefined: MULT is skipped for zero bits, as in Operation.

## Test plan
- WIDTH=1024, multiplier model with k=3:
  - N = 0xccd6…249d, M = 0x8eb6…2afe, exp=0x9985, exp_len=16.
  - Required: 25 ops, `done` at cycle 101, `result` equals the golden M^t mod N.
  - With `RSA_CTRL_CONST_TIME_EN`: 34 ops, `done` at cycle 137, same result.
- exp_len=0 → two ops (TO_MONT, FROM_MONT), `result`=1, `done` at cycle 9.
- exp=1, exp_len=1 → 4 ops, `result`=M; `mm_a`/`mm_b` stable between each mm_start and mm_done.
- exp_len=33 → err=1, `done` at cycle 1, `mm_start` never asserted, busy stays 0.
- `start` re-pulsed at cycle 20 with a different `exp` → ignored; result matches the first request.
- `resetn` low at cycle 50 → all outputs 0 within the reset assertion. A fresh start after release completes correctly with the k=3 timing.
